// File: rtl/bgm_sequencer.sv
// Background-music note sequencer: steps through a note table at a fixed tick rate
// and phase-accumulates the current note into the codec sample on each data_over edge.
module bgm_sequencer #(
    parameter int DATA_W      = 16,
    parameter int NOTE_W      = 8,
    parameter int DEPTH       = 128,
    parameter int STEP_TICKS  = 50000,
    parameter int STEREO_MODE = 0,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Init_Finish,
    input  logic              data_over,
    input  logic              play,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [AW:0]       seq_len,
    input  logic              tbl_we,
    input  logic [AW-1:0]     tbl_addr,
    input  logic [NOTE_W-1:0] tbl_data,
    output logic [DATA_W-1:0] LDATA,
    output logic [DATA_W-1:0] RDATA,
    output logic              Init,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     step_idx
);

    localparam int TW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [DATA_W-1:0] RDATA_RST = (STEREO_MODE != 0) ? '0 : '1;

    typedef enum logic [1:0] {INIT, IDLE, PLAY} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [TW-1:0]     tick;
    logic [AW:0]       len;
    logic [NOTE_W-1:0] note;
    logic [DATA_W-1:0] acc;
    logic              dov_q;
    logic [NOTE_W-1:0] mem [DEPTH];

    logic              len_ok;
    logic              play_ok;
    logic              step_end;
    logic              last_step;
    logic              finish;
    logic              sample_edge;
    logic [AW-1:0]     rd_addr;
    logic [NOTE_W-1:0] rd_data;

    always_comb begin
        len_ok      = (seq_len != '0) && (seq_len <= (AW+1)'(DEPTH));
        play_ok     = play && !stop && len_ok && (state != INIT);
        step_end    = (state == PLAY) && (tick == TW'(STEP_TICKS - 1));
        last_step   = ({1'b0, step_idx} == (len - (AW+1)'(1)));
        finish      = step_end && last_step && !loop_en && !stop && !play_ok;
        sample_edge = data_over && !dov_q;
        rd_addr     = (play_ok || last_step) ? '0 : step_idx + 1'b1;
        // A write landing in the same cycle as a step entry is forwarded so the new note is used.
        rd_data     = (tbl_we && (tbl_addr == rd_addr)) ? tbl_data : mem[rd_addr];
    end

    always_ff @(posedge Clk) begin
        if (tbl_we) begin
            mem[tbl_addr] <= tbl_data;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (Init_Finish) state_nxt = IDLE;
            IDLE:    if (play_ok) state_nxt = PLAY;
            PLAY:    if (stop || finish) state_nxt = IDLE;
            default: state_nxt = INIT;
        endcase
    end

    always_comb begin
        Init = (state == INIT);
        busy = (state == PLAY);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tick     <= '0;
            step_idx <= '0;
            len      <= '0;
            note     <= '0;
            acc      <= '1;
            dov_q    <= 1'b0;
            done     <= 1'b0;
            LDATA    <= '1;
            RDATA    <= RDATA_RST;
        end else begin
            dov_q <= data_over;
            done  <= finish;
            LDATA <= acc;
            RDATA <= (STEREO_MODE != 0) ? ~acc : acc;
            if ((state == PLAY) && sample_edge) begin
                acc <= acc + DATA_W'(note);
            end
            if (play_ok) begin
                tick     <= '0;
                step_idx <= '0;
                len      <= seq_len;
                note     <= rd_data;
            end else if ((state == PLAY) && !stop) begin
                if (step_end) begin
                    tick <= '0;
                    if (!last_step) begin
                        step_idx <= step_idx + 1'b1;
                        note     <= rd_data;
                    end else if (loop_en) begin
                        step_idx <= '0;
                        note     <= rd_data;
                    end
                end else begin
                    tick <= tick + 1'b1;
                end
            end
        end
    end

endmodule
